// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO pair.
// Results are computed at the start edge and committed when the busy counter expires.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = (MAX_CYCLES < 1) ? 1 : $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] MULT_CNT = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_CNT  = CW'(DIV_CYCLES);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic          commit_q, commit_d;

    logic        idle, long_op, div_signed;
    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

    assign idle    = (cnt_q == '0);
    assign long_op = start && (md_op == OP_MULT || md_op == OP_MULTU ||
                               md_op == OP_DIV  || md_op == OP_DIVU);
    assign busy    = long_op || !idle;

    // Sign-extending to 64 bits makes the unsigned multiply yield the exact signed product.
    assign prod = (md_op == OP_MULT) ? ({{32{A[31]}}, A} * {{32{B[31]}}, B})
                                     : ({32'b0, A} * {32'b0, B});

    // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping.
    assign div_signed = (md_op == OP_DIV);
    assign a_mag = (div_signed && A[31]) ? -A : A;
    assign b_mag = (div_signed && B[31]) ? -B : B;
    assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
    assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
    assign quot  = (div_signed && (A[31] ^ B[31])) ? -q_mag : q_mag;
    assign rem   = (div_signed && A[31]) ? -r_mag : r_mag;

    always_comb begin
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        commit_d  = commit_q;
        if (!idle) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1) && commit_q) begin
                hi_d = pend_hi_q;
                lo_d = pend_lo_q;
            end
        end else if (start) begin
            case (md_op)
                OP_MULT, OP_MULTU: begin
                    pend_hi_d = prod[63:32];
                    pend_lo_d = prod[31:0];
                    commit_d  = 1'b1;
                    cnt_d     = MULT_CNT;
                end
                OP_DIV, OP_DIVU: begin
                    pend_hi_d = rem;
                    pend_lo_d = quot;
                    // A zero divisor still occupies the unit but never commits.
                    commit_d  = (B != '0);
                    cnt_d     = DIV_CNT;
                end
                OP_MTHI: hi_d = A;
                OP_MTLO: lo_d = A;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            commit_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            commit_q  <= commit_d;
        end
    end

    assign HI = hi_q;
    assign LO = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Bench for mdu_unit: vector table driven through a result scoreboard, plus
// overlap, abort and reset-priority sequences.
module tb_mdu_unit;
    localparam logic [2:0] OP_NONE = 3'd0, OP_MULT = 3'd1, OP_MULTU = 3'd2,
                           OP_DIV = 3'd3, OP_DIVU = 3'd4, OP_MTHI = 3'd5,
                           OP_MTLO = 3'd6, OP_RSVD = 3'd7;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = OP_NONE;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy;
    logic [31:0] HI, LO;

    int          n_chk = 0;
    int          n_fail = 0;
    exp_t        sb[$];
    logic [31:0] mdl_hi = '0;
    logic [31:0] mdl_lo = '0;
    vec_t        tbl[$];

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input logic [2:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] hi,
                                input logic [31:0] lo, input int cyc);
        vec_t v;
        v.name = nm; v.op = op; v.a = a; v.b = b; v.hi = hi; v.lo = lo; v.cyc = cyc;
        return v;
    endfunction

    // inj_at: run cycle where a stray DIVU start is driven; rst_at: run cycle where reset hits.
    task automatic do_op(input vec_t v, input int inj_at, input int rst_at);
        exp_t e;
        @(negedge clk);
        start = 1'b1; md_op = v.op; A = v.a; B = v.b;
        #1 chk({v.name, " busy@start"}, 64'(busy), 64'(v.cyc > 0));
        e.hi = v.hi; e.lo = v.lo;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0; md_op = OP_NONE; A = $urandom; B = $urandom;
        for (int i = 1; i <= v.cyc; i++) begin
            if (i == inj_at) begin
                start = 1'b1; md_op = OP_DIVU; A = 32'd100; B = 32'd7;
            end
            if (i == rst_at) reset = 1'b1;
            #1;
            chk($sformatf("%s busy@run%0d", v.name, i), 64'(busy), 64'd1);
            chk($sformatf("%s hilo@run%0d", v.name, i), {HI, LO}, {mdl_hi, mdl_lo});
            @(negedge clk);
            start = 1'b0; md_op = OP_NONE; reset = 1'b0;
            if (i == rst_at) break;
        end
        #1;
        e = sb.pop_front();
        if (rst_at > 0) begin
            e.hi = '0; e.lo = '0;
        end
        chk({v.name, " busy@done"}, 64'(busy), 64'd0);
        chk({v.name, " result"}, {HI, LO}, {e.hi, e.lo});
        mdl_hi = e.hi; mdl_lo = e.lo;
    endtask

    initial begin
        tbl.push_back(mk("multu_max",  OP_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5));
        tbl.push_back(mk("mult_neg",   OP_MULT,  32'hFFFFFFFD, 32'h00000004, 32'hFFFFFFFF, 32'hFFFFFFF4, 5));
        tbl.push_back(mk("mult_min2",  OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5));
        tbl.push_back(mk("div_neg",    OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10));
        tbl.push_back(mk("div_ovf",    OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10));
        tbl.push_back(mk("div_negdiv", OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10));
        tbl.push_back(mk("divu",       OP_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 10));
        tbl.push_back(mk("mthi",       OP_MTHI,  32'h12345678, 32'h0,        32'h12345678, 32'h0000000E, 0));
        tbl.push_back(mk("mtlo",       OP_MTLO,  32'h9ABCDEF0, 32'h0,        32'h12345678, 32'h9ABCDEF0, 0));
        tbl.push_back(mk("divu_zero",  OP_DIVU,  32'h00000055, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 10));
        tbl.push_back(mk("mtlo_cafe",  OP_MTLO,  32'hCAFEBABE, 32'h0,        32'h12345678, 32'hCAFEBABE, 0));
        tbl.push_back(mk("op_none",    OP_NONE,  32'hDEADBEEF, 32'h1,        32'h12345678, 32'hCAFEBABE, 0));
        tbl.push_back(mk("op_rsvd",    OP_RSVD,  32'hDEADBEEF, 32'h1,        32'h12345678, 32'hCAFEBABE, 0));

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset hilo", {HI, LO}, 64'd0);
        reset = 1'b0;

        foreach (tbl[k]) do_op(tbl[k], 0, 0);

        // Stray DIVU on the third busy cycle must be ignored.
        do_op(mk("mult_overlap", OP_MULT, 32'h00000003, 32'h00000005, 32'h0, 32'h0000000F, 5), 2, 0);

        // Reset at the third run cycle aborts the multiply.
        do_op(mk("mult_abort", OP_MULT, 32'h0000FFFF, 32'h0000FFFF, 32'h0, 32'h0, 5), 0, 3);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            chk($sformatf("abort idle busy%0d", i), 64'(busy), 64'd0);
            chk($sformatf("abort idle hilo%0d", i), {HI, LO}, 64'd0);
        end

        // Reset wins over a same-cycle MTHI and MULT start.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; md_op = OP_MTHI; A = 32'hDEADBEEF;
        @(negedge clk);
        md_op = OP_MULT; A = 32'h7; B = 32'h9;
        @(negedge clk);
        reset = 1'b0; start = 1'b0; md_op = OP_NONE;
        #1;
        chk("rst_prio busy", 64'(busy), 64'd0);
        chk("rst_prio hilo", {HI, LO}, 64'd0);

        chk("scoreboard empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu_unit.md
MDU_UNIT -- requirements
Module: mdu_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU after the start cycle.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU after the start cycle.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: Execute-stage instruction with a valid md_op is present this cycle.
REQ-006 SHALL have port md_op, input, 3 bits: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
REQ-007 SHALL have port A, input, 32 bits: forwarded rs operand from the Execute stage.
REQ-008 SHALL have port B, input, 32 bits: forwarded rt operand from the Execute stage.
REQ-009 SHALL have port busy, output, 1 bit: MDU occupied; consumed by the hazard unit to stall any Decode-stage MDU instruction.
REQ-010 SHALL have port HI, output, 32 bits: architectural HI register.
REQ-011 SHALL have port LO, output, 32 bits: architectural LO register.

Function
REQ-012 SHALL hold a busy counter cnt and pending result registers pend_hi and pend_lo.
- Two states: IDLE (cnt == 0) and RUN (cnt > 0).
REQ-013 In IDLE, start=1 with MULT/MULTU SHALL do the following at the edge:
- compute the 64-bit product of A and B (signed for MULT, unsigned for MULTU);
- latch the high half into pend_hi and the low half into pend_lo;
- load cnt = MULT_CYCLES.
REQ-014 In IDLE, start=1 with DIV/DIVU SHALL do the following at the edge:
- latch the quotient into pend_lo and the remainder into pend_hi;
- load cnt = DIV_CYCLES.
REQ-015 Signed division SHALL follow these rules:
- the quotient truncates toward zero;
- the remainder takes the sign of the dividend;
- 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0.
REQ-016 Division with B == 0 SHALL still enter RUN for DIV_CYCLES, and SHALL leave HI/LO unchanged at completion.
REQ-017 In RUN, cnt SHALL decrement by 1 at each edge.
- At the edge where cnt goes 1 -> 0, HI <= pend_hi and LO <= pend_lo.
- HI/LO SHALL NOT change at any other time during RUN.
REQ-018 busy SHALL equal (start & md_op in {1,2,3,4}) | (cnt != 0), combinationally.
- Consequently, busy is high for exactly N+1 cycles per operation, including the start cycle.
REQ-019 In IDLE, start=1 with MTHI SHALL write HI <= A at the edge, take no RUN cycles, and keep busy low.
- MTLO SHALL do the same for LO <= A.
REQ-020 start=1 while in RUN SHALL be ignored: no state change and no operand capture.
- The hazard unit guarantees this case does not occur; the block SHALL still remain safe if it does.
REQ-021 start=1 with NONE or reserved md_op SHALL have no effect.
REQ-022 HI/LO SHALL be readable at every cycle (MFHI/MFLO is served via forwarding).
- During RUN, HI/LO SHALL show the pre-operation values.
REQ-023 Arithmetic width rules:
- the product SHALL be a full 64 bits with no truncation before the split;
- cnt SHALL be wide enough for max(MULT_CYCLES, DIV_CYCLES).

Reset
REQ-024 When reset=1 at an edge, the block SHALL set HI=0, LO=0, cnt=0, pend_hi=0 and pend_lo=0.
REQ-025 Reset during RUN SHALL abort the operation:
- no commit occurs;
- busy SHALL drop in the cycle after the reset edge, unless start is high.
REQ-026 reset SHALL take priority over start and over completion in the same cycle.

Verification
REQ-027 Unsigned multiply:
- stimulus: MULTU with A=0xFFFFFFFF, B=0x00000002;
- required: busy high for 6 cycles, then HI=0x00000001 and LO=0xFFFFFFFE, both appearing exactly 5 edges after the start edge.
REQ-028 Signed multiply:
- stimulus: MULT with A=0xFFFFFFFD (-3), B=0x00000004;
- required: HI=0xFFFFFFFF, LO=0xFFFFFFF4.
REQ-029 Signed divide:
- stimulus: DIV with A=0xFFFFFFF9 (-7), B=0x00000002;
- required: after 10 edges, LO=0xFFFFFFFD and HI=0xFFFFFFFF; busy high for 11 cycles.
REQ-030 Divide by zero:
- stimulus: preload with MTHI A=0x12345678 and MTLO A=0x9ABCDEF0, then DIVU with B=0;
- required: busy runs 11 cycles, and HI/LO stay 0x12345678/0x9ABCDEF0.
REQ-031 Overlap and abort:
- stimulus: MULT start, then start=1 with DIVU on the third busy cycle;
- required: the DIVU is ignored and the result is the MULT product.
- stimulus: a separate MULT with reset asserted at the 3rd RUN cycle;
- required: HI=LO=0, busy low afterward, and no late commit.
REQ-032 MTLO/MTHI timing:
- stimulus: MTLO with A=0xCAFEBABE in IDLE;
- required: LO=0xCAFEBABE after one edge, busy never asserted.
